// File: rtl/fp_vector_sum_seq_if.sv
// Handshake bundle for the vector-sum sequencer: element input, adder operand/result
// channels and the final sum output, each a stb/ack pair.
interface fp_vector_sum_seq_if;
    logic [31:0] in_data;
    logic        in_stb;
    logic        in_ack;
    logic [31:0] add_a;
    logic        add_a_stb;
    logic        add_a_ack;
    logic [31:0] add_b;
    logic        add_b_stb;
    logic        add_b_ack;
    logic [31:0] add_z;
    logic        add_z_stb;
    logic        add_z_ack;
    logic [31:0] sum;
    logic        sum_stb;
    logic        sum_ack;

    modport master (
        input  in_data, in_stb,
        output in_ack,
        output add_a, add_a_stb,
        input  add_a_ack,
        output add_b, add_b_stb,
        input  add_b_ack,
        input  add_z, add_z_stb,
        output add_z_ack,
        output sum, sum_stb,
        input  sum_ack
    );

    modport slave (
        output in_data, in_stb,
        input  in_ack,
        input  add_a, add_a_stb,
        output add_a_ack,
        input  add_b, add_b_stb,
        output add_b_ack,
        output add_z, add_z_stb,
        input  add_z_ack,
        input  sum, sum_stb,
        output sum_ack
    );
endinterface

// File: rtl/fp_vector_sum_seq.sv
// Reduces N single-precision elements to one sum by sequencing an external adder
// in fixed order ((e0+e1)+e2)+...; all handshake outputs are registered.
module fp_vector_sum_seq #(
    parameter int N = 4
) (
    input  logic                clk,
    input  logic                rst,
    fp_vector_sum_seq_if.master bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [2:0] {GET_FIRST, GET_NEXT, SEND_AB, WAIT_Z, PUT_SUM} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [31:0]   acc, acc_d;
    logic [31:0]   opb, opb_d;
    logic          a_done, a_done_d;
    logic          b_done, b_done_d;
    logic          in_ack_d, add_a_stb_d, add_b_stb_d, add_z_ack_d, sum_stb_d;
    logic [31:0]   add_a_d, add_b_d, sum_d;
    logic          a_fire, b_fire;

    assign a_fire = bus.add_a_stb && bus.add_a_ack;
    assign b_fire = bus.add_b_stb && bus.add_b_ack;

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        acc_d       = acc;
        opb_d       = opb;
        a_done_d    = a_done;
        b_done_d    = b_done;
        in_ack_d    = 1'b0;
        add_a_stb_d = 1'b0;
        add_b_stb_d = 1'b0;
        add_z_ack_d = 1'b0;
        sum_stb_d   = 1'b0;
        add_a_d     = bus.add_a;
        add_b_d     = bus.add_b;
        sum_d       = bus.sum;
        case (state)
            GET_FIRST: begin
                in_ack_d = 1'b1;
                if (bus.in_stb && bus.in_ack) begin
                    acc_d    = bus.in_data;
                    cnt_d    = CW'(1);
                    in_ack_d = 1'b0;
                    state_d  = (N == 1) ? PUT_SUM : GET_NEXT;
                end
            end
            GET_NEXT: begin
                in_ack_d = 1'b1;
                if (bus.in_stb && bus.in_ack) begin
                    opb_d    = bus.in_data;
                    cnt_d    = cnt + CW'(1);
                    in_ack_d = 1'b0;
                    state_d  = SEND_AB;
                end
            end
            SEND_AB: begin
                // A and B complete independently; leave only once both have been taken.
                add_a_d     = acc;
                add_b_d     = opb;
                add_a_stb_d = !a_done && !a_fire;
                add_b_stb_d = !b_done && !b_fire;
                if (a_fire) a_done_d = 1'b1;
                if (b_fire) b_done_d = 1'b1;
                if ((a_done || a_fire) && (b_done || b_fire)) begin
                    a_done_d = 1'b0;
                    b_done_d = 1'b0;
                    state_d  = WAIT_Z;
                end
            end
            WAIT_Z: begin
                add_z_ack_d = 1'b1;
                if (bus.add_z_stb && bus.add_z_ack) begin
                    acc_d       = bus.add_z;
                    add_z_ack_d = 1'b0;
                    state_d     = (cnt == CW'(N)) ? PUT_SUM : GET_NEXT;
                end
            end
            PUT_SUM: begin
                sum_d     = acc;
                sum_stb_d = 1'b1;
                if (bus.sum_stb && bus.sum_ack) begin
                    sum_stb_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = GET_FIRST;
                end
            end
            default: state_d = GET_FIRST;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= GET_FIRST;
            cnt           <= '0;
            acc           <= '0;
            opb           <= '0;
            a_done        <= 1'b0;
            b_done        <= 1'b0;
            bus.in_ack    <= 1'b0;
            bus.add_a     <= '0;
            bus.add_a_stb <= 1'b0;
            bus.add_b     <= '0;
            bus.add_b_stb <= 1'b0;
            bus.add_z_ack <= 1'b0;
            bus.sum       <= '0;
            bus.sum_stb   <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            acc           <= acc_d;
            opb           <= opb_d;
            a_done        <= a_done_d;
            b_done        <= b_done_d;
            bus.in_ack    <= in_ack_d;
            bus.add_a     <= add_a_d;
            bus.add_a_stb <= add_a_stb_d;
            bus.add_b     <= add_b_d;
            bus.add_b_stb <= add_b_stb_d;
            bus.add_z_ack <= add_z_ack_d;
            bus.sum       <= sum_d;
            bus.sum_stb   <= sum_stb_d;
        end
    end
endmodule

// File: tb/tb_fp_vector_sum_seq.sv
// Bench for fp_vector_sum_seq: an N=4 instance driven against a behavioural adder and
// an N=1 instance; expected sums come from integer arithmetic on the element values.
module tb_fp_vector_sum_seq;
    localparam int M_OFF = 0, M_NORMAL = 1, M_STALL = 2, M_STALE = 3, M_RAND = 4;

    logic clk;
    logic rst;

    fp_vector_sum_seq_if b4();
    fp_vector_sum_seq_if b1();

    fp_vector_sum_seq #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    fp_vector_sum_seq #(.N(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    int checks = 0;
    int errors = 0;
    int adder_mode = M_OFF;
    int a_dly = 0;
    int b_dly = 0;
    int zack_early = 0;
    int n1_opstb = 0;
    logic [31:0] pa[$];
    logic [31:0] pb[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Integer to single-precision bits (exact for |v| < 2^24).
    function automatic logic [31:0] i2f(input int v);
        logic        s;
        logic [31:0] mag;
        logic [31:0] m;
        int          p;
        if (v == 0) return 32'h0;
        s   = (v < 0);
        mag = s ? 32'(-v) : 32'(v);
        p   = 31;
        while (!mag[p]) p--;
        m = mag << (23 - p);
        return {s, 8'(p + 127), m[22:0]};
    endfunction

    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:23] == 8'd0) return 0.0;
        e = 11'(f[30:23]) + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural adder on the N=4 instance's operand/result channels.
    initial begin : adder_model
        logic        a_tk, b_tk, z_v, z_x;
        logic [31:0] oa, ob, zv;
        int          a_w, b_w;
        a_tk = 0; b_tk = 0; z_v = 0; z_x = 0; a_w = 0; b_w = 0;
        oa = 0; ob = 0; zv = 0;
        b4.add_a_ack = 0; b4.add_b_ack = 0; b4.add_z_stb = 0; b4.add_z = 0;
        forever begin
            @(negedge clk);
            if (adder_mode == M_NORMAL || adder_mode == M_STALL) begin
                if (z_x) begin
                    a_tk = 0; b_tk = 0; z_v = 0; z_x = 0; a_w = 0; b_w = 0;
                end
                if (b4.add_z_ack && !(a_tk && b_tk)) zack_early++;
                b4.add_a_ack = 0;
                if (b4.add_a_stb && !a_tk) begin
                    if (a_w >= a_dly) begin
                        b4.add_a_ack = 1; a_tk = 1; oa = b4.add_a; pa.push_back(b4.add_a);
                    end else a_w++;
                end
                b4.add_b_ack = 0;
                if (b4.add_b_stb && !b_tk) begin
                    if (b_w >= b_dly) begin
                        b4.add_b_ack = 1; b_tk = 1; ob = b4.add_b; pb.push_back(b4.add_b);
                    end else b_w++;
                end
                if (a_tk && b_tk && !z_v && adder_mode == M_NORMAL) begin
                    z_v = 1;
                    zv  = r2f(f2r(oa) + f2r(ob));
                end
                z_x = z_v && b4.add_z_ack;
                b4.add_z_stb = z_v;
                b4.add_z     = zv;
            end else begin
                a_tk = 0; b_tk = 0; z_v = 0; z_x = 0; a_w = 0; b_w = 0;
                if (adder_mode == M_RAND) begin
                    b4.add_a_ack = 1'($urandom_range(1));
                    b4.add_b_ack = 1'($urandom_range(1));
                    b4.add_z_stb = 1'($urandom_range(1));
                    b4.add_z     = $urandom;
                end else if (adder_mode == M_STALE) begin
                    b4.add_a_ack = 0; b4.add_b_ack = 0;
                    b4.add_z_stb = 1; b4.add_z = 32'h447A0000;
                end else begin
                    b4.add_a_ack = 0; b4.add_b_ack = 0; b4.add_z_stb = 0; b4.add_z = 0;
                end
            end
        end
    end

    initial begin : n1_monitor
        forever begin
            @(negedge clk);
            if (b1.add_a_stb || b1.add_b_stb) n1_opstb++;
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    task automatic send4(input logic [31:0] d);
        int t;
        t = 0;
        b4.in_data = d;
        b4.in_stb  = 1;
        while (!b4.in_ack && t < 200) begin @(negedge clk); t++; end
        chk("send_timeout", 32'(t < 200), 32'd1);
        @(negedge clk);
        b4.in_stb = 0;
    endtask

    task automatic recv4(output logic [31:0] s, input int stall);
        int t;
        t = 0;
        b4.sum_ack = 0;
        while (!b4.sum_stb && t < 2000) begin @(negedge clk); t++; end
        chk("sum_timeout", 32'(t < 2000), 32'd1);
        repeat (stall) @(negedge clk);
        s = b4.sum;
        b4.sum_ack = 1;
        @(negedge clk);
        b4.sum_ack = 0;
    endtask

    task automatic run_vec(input int e[4], input int stall, input string tag,
                           output logic [31:0] s);
        int run;
        pa.delete();
        pb.delete();
        for (int i = 0; i < 4; i++) send4(i2f(e[i]));
        recv4(s, stall);
        chk({tag, "_sum"}, s, i2f(e[0] + e[1] + e[2] + e[3]));
        chk({tag, "_npairs"}, 32'(pa.size() * 16 + pb.size()), 32'h33);
        run = e[0];
        for (int k = 1; k < 4; k++) begin
            if (pa.size() >= k && pb.size() >= k) begin
                chk({tag, "_opA"}, pa[k-1], i2f(run));
                chk({tag, "_opB"}, pb[k-1], i2f(e[k]));
            end
            run += e[k];
        end
    endtask

    initial begin : main
        int          t;
        int          e[4];
        int          tot;
        logic [31:0] s, s0, held_b, n1_exp;

        rst = 1;
        b4.in_stb = 0; b4.in_data = 0; b4.sum_ack = 0;
        b1.in_stb = 0; b1.in_data = 0; b1.sum_ack = 0;
        b1.add_a_ack = 0; b1.add_b_ack = 0; b1.add_z_stb = 0; b1.add_z = 0;
        #2 rst = 0;
        adder_mode = M_RAND;

        // Reset held with random traffic on every input.
        repeat (5) begin
            @(negedge clk);
            b4.in_stb  = 1'($urandom_range(1)); b4.in_data = $urandom;
            b4.sum_ack = 1'($urandom_range(1));
            b1.in_stb  = 1'($urandom_range(1)); b1.in_data = $urandom;
            b1.sum_ack = 1'($urandom_range(1));
            #1;
            chk("rst_in_ack", 32'(b4.in_ack), 0);
            chk("rst_a_stb", 32'(b4.add_a_stb), 0);
            chk("rst_b_stb", 32'(b4.add_b_stb), 0);
            chk("rst_z_ack", 32'(b4.add_z_ack), 0);
            chk("rst_sum_stb", 32'(b4.sum_stb), 0);
            chk("rst_sum", b4.sum, 0);
            chk("rst_add_a", b4.add_a, 0);
            chk("rst_add_b", b4.add_b, 0);
            chk("rst_n1_in_ack", 32'(b1.in_ack), 0);
            chk("rst_n1_sum_stb", 32'(b1.sum_stb), 0);
        end
        @(negedge clk);
        rst = 1;
        adder_mode = M_OFF;
        b4.in_stb = 0; b4.sum_ack = 0; b1.in_stb = 0; b1.sum_ack = 0;
        @(negedge clk);
        chk("rel_in_ack", 32'(b4.in_ack), 1);
        chk("rel_n1_in_ack", 32'(b1.in_ack), 1);
        chk("rel_a_stb", 32'(b4.add_a_stb), 0);
        chk("rel_b_stb", 32'(b4.add_b_stb), 0);

        // Directed 1+2+3+4 with immediate acks.
        adder_mode = M_NORMAL; a_dly = 0; b_dly = 0;
        e = '{1, 2, 3, 4};
        run_vec(e, 0, "dir", s);
        chk("dir_sum_lit", s, 32'h41200000);

        // B accepted three cycles after A.
        a_dly = 0; b_dly = 3;
        pa.delete(); pb.delete();
        send4(i2f(5));
        send4(i2f(6));
        t = 0;
        while (!b4.add_a_stb && t < 50) begin @(negedge clk); t++; end
        chk("stag_timeout", 32'(t < 50), 32'd1);
        chk("stag_a_val", b4.add_a, i2f(5));
        held_b = b4.add_b;
        chk("stag_b_val", held_b, i2f(6));
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("stag_a_stb", 32'(b4.add_a_stb), 0);
            chk("stag_b_stb", 32'(b4.add_b_stb), 1);
            chk("stag_b_hold", b4.add_b, held_b);
            chk("stag_z_ack", 32'(b4.add_z_ack), 0);
        end
        send4(i2f(7));
        send4(i2f(8));
        recv4(s, 0);
        chk("stag_sum", s, i2f(26));

        // Sum held for 20 cycles while a new element is already offered.
        a_dly = 1; b_dly = 0;
        for (int i = 0; i < 4; i++) e[i] = int'($urandom_range(200)) - 100;
        tot = e[0] + e[1] + e[2] + e[3];
        for (int i = 0; i < 4; i++) send4(i2f(e[i]));
        t = 0;
        while (!b4.sum_stb && t < 200) begin @(negedge clk); t++; end
        chk("stall_timeout", 32'(t < 200), 32'd1);
        s0 = b4.sum;
        chk("stall_sum_val", s0, i2f(tot));
        b4.in_data = i2f(9);
        b4.in_stb  = 1;
        for (int k = 0; k < 20; k++) begin
            chk("stall_sum_stb", 32'(b4.sum_stb), 1);
            chk("stall_sum_hold", b4.sum, s0);
            chk("stall_in_ack", 32'(b4.in_ack), 0);
            @(negedge clk);
        end
        b4.sum_ack = 1;
        @(negedge clk);
        b4.sum_ack = 0;
        chk("stall_post_in_ack", 32'(b4.in_ack), 0);
        send4(i2f(9));
        send4(i2f(-2));
        send4(i2f(40));
        send4(i2f(3));
        recv4(s, 0);
        chk("stall_next_sum", s, i2f(50));

        // Randomised vectors with random adder and sink latencies.
        for (int v = 0; v < 6; v++) begin
            a_dly = int'($urandom_range(3));
            b_dly = int'($urandom_range(3));
            for (int i = 0; i < 4; i++) e[i] = int'($urandom_range(2000)) - 1000;
            run_vec(e, int'($urandom_range(3)), "rnd", s);
        end

        // Reset while waiting on the adder result, then a stale result strobe.
        a_dly = 0; b_dly = 0;
        adder_mode = M_STALL;
        send4(i2f(7));
        send4(i2f(11));
        t = 0;
        while (!b4.add_z_ack && t < 50) begin @(negedge clk); t++; end
        chk("mid_timeout", 32'(t < 50), 32'd1);
        rst = 0;
        adder_mode = M_STALE;
        #1;
        chk("mid_in_ack", 32'(b4.in_ack), 0);
        chk("mid_a_stb", 32'(b4.add_a_stb), 0);
        chk("mid_b_stb", 32'(b4.add_b_stb), 0);
        chk("mid_z_ack", 32'(b4.add_z_ack), 0);
        chk("mid_sum_stb", 32'(b4.sum_stb), 0);
        chk("mid_add_a", b4.add_a, 0);
        chk("mid_add_b", b4.add_b, 0);
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("mid_rel_in_ack", 32'(b4.in_ack), 1);
        send4(32'h3F800000);
        adder_mode = M_NORMAL;
        send4(32'h3F800000);
        send4(32'h3F800000);
        send4(32'h3F800000);
        recv4(s, 0);
        chk("mid_sum", s, 32'h40800000);
        chk("zack_before_operands", 32'(zack_early), 0);

        // N=1 instance: element passes straight to the sum.
        for (int v = 0; v < 2; v++) begin
            n1_exp = (v == 0) ? 32'hC0000000 : i2f(int'($urandom_range(2000)) - 1000);
            b1.in_data = n1_exp;
            b1.in_stb  = 1;
            t = 0;
            while (!b1.in_ack && t < 50) begin @(negedge clk); t++; end
            chk("n1_in_timeout", 32'(t < 50), 32'd1);
            @(negedge clk);
            b1.in_stb = 0;
            t = 0;
            while (!b1.sum_stb && t < 50) begin @(negedge clk); t++; end
            chk("n1_sum_timeout", 32'(t < 50), 32'd1);
            chk("n1_sum", b1.sum, n1_exp);
            b1.sum_ack = 1;
            @(negedge clk);
            b1.sum_ack = 0;
            @(negedge clk);
        end
        chk("n1_no_operands", 32'(n1_opstb), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
